// File: rtl/bsg_hash_bank_seq.sv
// Sequential address hasher: splits an address into (bank, index) with
// bank = i mod banks_p and index = i / banks_p. Power-of-two bank counts
// resolve in one cycle; other counts run a bit-serial restoring divider.
module bsg_hash_bank_seq #(
    parameter int unsigned width_p  = 32,
    parameter int unsigned banks_p  = 3,
    localparam int unsigned lg_banks_lp    = (banks_p > 1) ? $clog2(banks_p) : 1,
    localparam int unsigned floor_lg_lp    = $clog2(banks_p + 1) - 1,
    localparam int unsigned index_width_lp = width_p - floor_lg_lp
) (
    input  logic                      clk_i,
    input  logic                      reset_i,
    input  logic                      v_i,
    input  logic [width_p-1:0]        i,
    output logic                      ready_o,
    output logic                      v_o,
    output logic [lg_banks_lp-1:0]    bank_o,
    output logic [index_width_lp-1:0] index_o,
    input  logic                      yumi_i
);

    localparam bit pow2_lp = ((banks_p & (banks_p - 1)) == 0);
    localparam int unsigned cnt_width_lp = $clog2(width_p);
    localparam logic [lg_banks_lp:0] banks_lp = (lg_banks_lp + 1)'(banks_p);
    localparam logic [cnt_width_lp-1:0] cnt_last_lp = cnt_width_lp'(width_p - 1);
    localparam logic [width_p-1:0] bank_mask_lp = width_p'(banks_p - 1);

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

    state_e                      state_q, state_d;
    logic [cnt_width_lp-1:0]     cnt_q, cnt_d;
    logic [width_p-1:0]          div_q, div_d;   // dividend, shifted out MSB first
    logic [lg_banks_lp-1:0]      rem_q, rem_d;   // remainder, always < banks_p
    logic [index_width_lp-1:0]   quo_q, quo_d;   // quotient; dropped high bits are always 0
    logic [lg_banks_lp:0]        partial;        // one extra bit so 2*banks_p-1 never overflows

    // Next-state: accept in idle, one quotient bit per busy cycle, hold until consumed
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        div_d   = div_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        partial = {rem_q, div_q[width_p-1]};
        unique case (state_q)
            StIdle: begin
                if (v_i) begin
                    if (pow2_lp) begin
                        rem_d   = lg_banks_lp'(i & bank_mask_lp);
                        quo_d   = index_width_lp'(i >> floor_lg_lp);
                        state_d = StDone;
                    end else begin
                        div_d   = i;
                        rem_d   = '0;
                        quo_d   = '0;
                        cnt_d   = '0;
                        state_d = StBusy;
                    end
                end
            end
            StBusy: begin
                div_d = div_q << 1;
                if (partial >= banks_lp) begin
                    rem_d = lg_banks_lp'(partial - banks_lp);
                    quo_d = (quo_q << 1) | index_width_lp'(1);
                end else begin
                    rem_d = partial[lg_banks_lp-1:0];
                    quo_d = quo_q << 1;
                end
                cnt_d = cnt_q + cnt_width_lp'(1);
                if (cnt_q == cnt_last_lp) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                if (yumi_i) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State registers with synchronous reset abandoning any transaction
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            div_q   <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            div_q   <= div_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
        end
    end

    assign ready_o = (state_q == StIdle);
    assign v_o     = (state_q == StDone);
    assign bank_o  = rem_q;
    assign index_o = quo_q;

endmodule

// File: tb/tb_bsg_hash_bank_seq.sv
// Bench for bsg_hash_bank_seq: directed latency/boundary/backpressure/reset
// cases on three small instances plus randomized traffic on ten configurations.
module tb_bsg_hash_bank_seq;

    logic clk;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   rnd_done_cnt = 0;
    logic rnd_go;
    logic rrst;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // ---------------- directed instances (shared stimulus, gated by sel) ----------------
    logic       drst, dv, dy;
    logic [7:0] di;
    int         sel;

    logic       v3, y3, r3, o3;
    logic [1:0] b3;
    logic [6:0] x3;
    logic       v4, y4, r4, o4;
    logic [1:0] b4;
    logic [5:0] x4;
    logic       v1, y1, r1, o1;
    logic [0:0] b1;
    logic [7:0] x1;

    assign v3 = dv && (sel == 0);
    assign y3 = dy && (sel == 0);
    assign v4 = dv && (sel == 1);
    assign y4 = dy && (sel == 1);
    assign v1 = dv && (sel == 2);
    assign y1 = dy && (sel == 2);

    bsg_hash_bank_seq #(.width_p(8), .banks_p(3)) u_d3 (
        .clk_i(clk), .reset_i(drst), .v_i(v3), .i(di), .ready_o(r3), .v_o(o3),
        .bank_o(b3), .index_o(x3), .yumi_i(y3)
    );
    bsg_hash_bank_seq #(.width_p(8), .banks_p(4)) u_d4 (
        .clk_i(clk), .reset_i(drst), .v_i(v4), .i(di), .ready_o(r4), .v_o(o4),
        .bank_o(b4), .index_o(x4), .yumi_i(y4)
    );
    bsg_hash_bank_seq #(.width_p(8), .banks_p(1)) u_d1 (
        .clk_i(clk), .reset_i(drst), .v_i(v1), .i(di), .ready_o(r1), .v_o(o1),
        .bank_o(b1), .index_o(x1), .yumi_i(y1)
    );

    logic        o_rdy, o_v;
    logic [63:0] o_bank, o_idx;

    always_comb begin
        o_rdy  = 1'b0;
        o_v    = 1'b0;
        o_bank = '0;
        o_idx  = '0;
        case (sel)
            0: begin o_rdy = r3; o_v = o3; o_bank = 64'(b3); o_idx = 64'(x3); end
            1: begin o_rdy = r4; o_v = o4; o_bank = 64'(b4); o_idx = 64'(x4); end
            2: begin o_rdy = r1; o_v = o1; o_bank = 64'(b1); o_idx = 64'(x1); end
            default: ;
        endcase
    end

    int eb_q[$];
    int ei_q[$];
    int el_q[$];

    function automatic int banks_of(input int s);
        return (s == 0) ? 3 : (s == 1) ? 4 : 1;
    endfunction

    // One transaction on instance s: push expectations, wait for v_o, hold, consume.
    task automatic xact(input int s, input logic [7:0] a, input int hold);
        int lat;
        int nb;
        logic [63:0] hb, hx;
        sel = s;
        #1;
        nb = banks_of(s);
        check_eq("ready_before_accept", 64'(o_rdy), 64'd1);
        dv = 1'b1;
        di = a;
        eb_q.push_back(int'(a) % nb);
        ei_q.push_back(int'(a) / nb);
        el_q.push_back(((nb & (nb - 1)) == 0) ? 1 : 9);
        @(negedge clk);
        dv  = 1'b0;
        di  = ~a;
        lat = 1;
        while (!o_v && lat < 40) begin
            dv = lat[0];
            di = 8'($urandom);
            @(negedge clk);
            lat++;
        end
        check_eq("latency", 64'(lat), 64'(el_q.pop_front()));
        hb = o_bank;
        hx = o_idx;
        for (int k = 0; k < hold; k++) begin
            check_eq("hold_v", 64'(o_v), 64'd1);
            check_eq("hold_ready", 64'(o_rdy), 64'd0);
            check_eq("hold_bank", o_bank, hb);
            check_eq("hold_index", o_idx, hx);
            dv = k[0];
            di = 8'($urandom);
            @(negedge clk);
        end
        check_eq("bank", o_bank, 64'(eb_q.pop_front()));
        check_eq("index", o_idx, 64'(ei_q.pop_front()));
        dy = 1'b1;
        dv = 1'b1;  // must not be taken in the yumi cycle
        di = 8'hAA;
        @(negedge clk);
        dy = 1'b0;
        dv = 1'b0;
        check_eq("ready_after_yumi", 64'(o_rdy), 64'd1);
        check_eq("v_after_yumi", 64'(o_v), 64'd0);
    endtask

    // ---------------- randomized instances ----------------
    for (genvar g = 0; g < 10; g++) begin : g_rnd
        localparam int unsigned W  = (g < 5) ? 8 : 32;
        localparam int unsigned B  = (g % 5 == 0) ? 1 : (g % 5 == 1) ? 3 :
                                     (g % 5 == 2) ? 5 : (g % 5 == 3) ? 8 : 12;
        localparam int unsigned LG = (B > 1) ? $clog2(B) : 1;
        localparam int unsigned IW = W - ($clog2(B + 1) - 1);

        logic          rv, ry, rready, rvo;
        logic [W-1:0]  ra;
        logic [LG-1:0] rbank;
        logic [IW-1:0] ridx;

        bsg_hash_bank_seq #(.width_p(W), .banks_p(B)) u_dut (
            .clk_i(clk), .reset_i(rrst), .v_i(rv), .i(ra), .ready_o(rready), .v_o(rvo),
            .bank_o(rbank), .index_o(ridx), .yumi_i(ry)
        );

        initial begin : run
            logic [W-1:0] exq[$];
            logic [W-1:0] e;
            int acc, outs, cyc;
            rv = 1'b0;
            ry = 1'b0;
            ra = '0;
            acc = 0;
            outs = 0;
            cyc = 0;
            wait (rnd_go);
            while ((acc < 1000 || exq.size() != 0) && cyc < 60000) begin
                @(negedge clk);
                cyc++;
                rv = (acc < 1000) && ($urandom_range(1, 0) == 1);
                ra = W'({$urandom, $urandom});
                ry = rvo && ($urandom_range(1, 0) == 1);
                if (rready && rv) begin
                    exq.push_back(ra);
                    acc++;
                end
                if (rvo && ry) begin
                    if (exq.size() == 0) begin
                        check_eq("rnd_unexpected_output", 64'd1, 64'd0);
                    end else begin
                        e = exq.pop_front();
                        outs++;
                        check_eq("rnd_bank", 64'(rbank), 64'(e % B));
                        check_eq("rnd_index", 64'(ridx), 64'(e / B));
                        check_eq("rnd_recombine", 64'(ridx) * 64'(B) + 64'(rbank), 64'(e));
                    end
                end
            end
            rv = 1'b0;
            ry = 1'b0;
            check_eq("rnd_drained", 64'(exq.size()), 64'd0);
            check_eq("rnd_one_per_accept", 64'(outs), 64'(acc));
            rnd_done_cnt++;
        end
    end

    // ---------------- main sequence ----------------
    initial begin
        int seen;
        drst = 1'b1;
        rrst = 1'b1;
        dv = 1'b1;  // valid during reset must not be taken
        dy = 1'b0;
        di = 8'h5A;
        sel = 0;
        rnd_go = 1'b0;
        repeat (3) @(negedge clk);
        drst = 1'b0;
        rrst = 1'b0;
        dv = 1'b0;
        check_eq("reset_ready", 64'(o_rdy), 64'd1);
        check_eq("reset_v", 64'(o_v), 64'd0);
        rnd_go = 1'b1;

        xact(0, 8'd200, 5);
        xact(0, 8'd255, 0);
        xact(0, 8'd0, 0);
        xact(0, 8'd1, 0);
        xact(1, 8'd183, 1);
        xact(1, 8'd255, 0);
        xact(2, 8'd77, 0);
        xact(2, 8'd255, 0);

        // Reset in the fourth busy cycle abandons the division
        sel = 0;
        #1;
        dv = 1'b1;
        di = 8'd200;
        @(negedge clk);
        dv = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("busy_ready", 64'(o_rdy), 64'd0);
        drst = 1'b1;
        dv = 1'b1;
        di = 8'd55;
        @(negedge clk);
        drst = 1'b0;
        dv = 1'b0;
        check_eq("midbusy_rst_ready", 64'(o_rdy), 64'd1);
        check_eq("midbusy_rst_v", 64'(o_v), 64'd0);
        seen = 0;
        repeat (12) begin
            @(negedge clk);
            if (o_v) seen = 1;
        end
        check_eq("no_pulse_after_rst", 64'(seen), 64'd0);
        xact(0, 8'd7, 0);

        for (int c = 0; c < 70000 && rnd_done_cnt < 10; c++) @(negedge clk);
        check_eq("rnd_all_done", 64'(rnd_done_cnt), 64'd10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
